// File: rtl/fft_pkg.sv
// Shared types and address helper for the radix-2 DIT FFT sequencer.
package fft_pkg;

    localparam int unsigned N_DEF        = 16;
    localparam int unsigned BFLY_LAT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] tw;
    } bfly_t;

    // Operand pair and twiddle index of butterfly k in stage s.
    function automatic bfly_t bfly_addr(input int unsigned log2n,
                                        input int unsigned s,
                                        input int unsigned k);
        int unsigned span;
        int unsigned pos;
        int unsigned grp;
        bfly_t       r;
        span = 32'd1 << s;
        pos  = k & (span - 32'd1);
        grp  = k >> s;
        r.a  = (grp << (s + 32'd1)) | pos;
        r.b  = r.a + span;
        r.tw = pos << (log2n - 32'd1 - s);
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-latency shift register that turns issued read addresses into write-back addresses.
module fft_addr_delay
    import fft_pkg::*;
#(
    parameter int unsigned LAT = 3,
    parameter int unsigned AW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic          en_o,
    output logic [AW-1:0] a_o,
    output logic [AW-1:0] b_o
);

    localparam int unsigned W = 1 + 2 * AW;

    logic [W-1:0] pipe_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {en_i, a_i, b_i};
            for (int i = 1; i < int'(LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {en_o, a_o, b_o} = pipe_q[LAT-1];

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: stage/butterfly walk, read issue and delayed write-back.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned BFLY_LAT = BFLY_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2($clog2(N))-1:0]  stage_o,
    output logic                          rd_en_o,
    output logic [$clog2(N)-1:0]          rd_addr_a_o,
    output logic [$clog2(N)-1:0]          rd_addr_b_o,
    output logic [$clog2(N)-2:0]          tw_addr_o,
    output logic                          wr_en_o,
    output logic [$clog2(N)-1:0]          wr_addr_a_o,
    output logic [$clog2(N)-1:0]          wr_addr_b_o
);

    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned AW    = LOG2N;
    localparam int unsigned TW    = LOG2N - 1;
    localparam int unsigned SW    = $clog2(LOG2N);
    localparam int unsigned KW    = LOG2N - 1;
    localparam int unsigned DW    = $clog2(BFLY_LAT + 1);

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_a_q, rd_a_d;
    logic [AW-1:0] rd_b_q, rd_b_d;
    logic [TW-1:0] tw_q, tw_d;
    bfly_t         bfly_c;
    logic          unused_hi_c;

    // Next state, counters, and the registered view of the cycle being entered.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (k_q == KW'(N / 2 - 1)) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == DW'(BFLY_LAT - 1)) begin
                    k_d = '0;
                    if (s_q == SW'(LOG2N - 1)) begin
                        state_d = DONE;
                        s_d     = '0;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + SW'(1);
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bfly_c  = bfly_addr(LOG2N, 32'(s_d), 32'(k_d));
        busy_d  = (state_d == RUN) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
        rd_en_d = (state_d == RUN);
        rd_a_d  = rd_en_d ? AW'(bfly_c.a)  : '0;
        rd_b_d  = rd_en_d ? AW'(bfly_c.b)  : '0;
        tw_d    = rd_en_d ? TW'(bfly_c.tw) : '0;
    end

    // Address bits above LOG2N are always zero for legal s, k.
    assign unused_hi_c = ^bfly_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign stage_o     = s_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_a_o = rd_a_q;
    assign rd_addr_b_o = rd_b_q;
    assign tw_addr_o   = tw_q;

    fft_addr_delay #(
        .LAT (BFLY_LAT),
        .AW  (AW)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .en_i (rd_en_q),
        .a_i  (rd_a_q),
        .b_i  (rd_b_q),
        .en_o (wr_en_o),
        .a_o  (wr_addr_a_o),
        .b_o  (wr_addr_b_o)
    );

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl (N=16, BFLY_LAT=3) against a cycle-indexed timeline model.
module tb_fft_ctrl;

    localparam int unsigned N      = 16;
    localparam int unsigned LAT    = 3;
    localparam int unsigned LOG2N  = 4;
    localparam int unsigned HALF   = N / 2;
    localparam int unsigned PER    = HALF + LAT;
    localparam int          T_LAST = LOG2N * PER;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic [1:0] stage_o;
    logic       rd_en_o;
    logic [3:0] rd_addr_a_o;
    logic [3:0] rd_addr_b_o;
    logic [2:0] tw_addr_o;
    logic       wr_en_o;
    logic [3:0] wr_addr_a_o;
    logic [3:0] wr_addr_b_o;

    int n_cmp = 0;
    int n_bad = 0;

    fft_ctrl #(.N(N), .BFLY_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .stage_o     (stage_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_a_o (rd_addr_a_o),
        .rd_addr_b_o (rd_addr_b_o),
        .tw_addr_o   (tw_addr_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_a_o (wr_addr_a_o),
        .wr_addr_b_o (wr_addr_b_o)
    );

    always #5 clk = ~clk;

    // Model state: mdl_t is the cycle index since the accepted start (-1 when idle).
    int          mdl_t    = -1;
    int          run_no   = 0;
    bit          seen_rst = 1'b0;
    bit          pin_zero = 1'b0;
    int unsigned hist[$];
    int unsigned e_busy, e_done, e_stage, e_rd, e_a, e_b, e_tw, e_wr, e_wa, e_wb;

    always @(posedge clk) begin
        int          st;
        int          idx;
        int          span;
        int unsigned cur;
        int unsigned old;
        if (rst) begin
            mdl_t    = -1;
            seen_rst = 1'b1;
            pin_zero = 1'b1;
            hist.delete();
            for (int i = 0; i < int'(LAT); i++) hist.push_back(0);
        end else if (mdl_t >= 0) begin
            mdl_t = mdl_t + 1;
            if (mdl_t > T_LAST + 1) mdl_t = -1;
        end else if (start_i) begin
            mdl_t  = 1;
            run_no = run_no + 1;
        end

        e_busy = 0; e_done = 0; e_stage = 0; e_rd = 0; e_a = 0; e_b = 0; e_tw = 0;
        if (mdl_t >= 1 && mdl_t <= T_LAST) begin
            e_busy  = 1;
            st      = (mdl_t - 1) / PER;
            idx     = (mdl_t - 1) % PER;
            e_stage = st;
            if (idx < int'(HALF)) begin
                span = 2 ** st;
                e_rd = 1;
                e_a  = (idx / span) * 2 * span + (idx % span);
                e_b  = e_a + span;
                e_tw = (idx % span) * (N / (2 * span));
            end
        end
        if (mdl_t == T_LAST + 1) e_done = 1;

        cur = (e_rd << 16) | (e_a << 8) | e_b;
        hist.push_back(cur);
        old  = (hist.size() > LAT) ? hist.pop_front() : 0;
        e_wr = old >> 16;
        e_wa = (old >> 8) & 8'hff;
        e_wb = old & 8'hff;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (run %0d, t=%0d, time %0t)",
                     nm, act, exp, run_no, mdl_t, $time);
        end
    endtask

    task automatic pin_rd(input string nm, input int a, input int b, input int tw);
        chk({nm, "_rd_en"}, 32'(rd_en_o), 1);
        chk({nm, "_rd_a"}, 32'(rd_addr_a_o), 32'(a));
        chk({nm, "_rd_b"}, 32'(rd_addr_b_o), 32'(b));
        chk({nm, "_tw"}, 32'(tw_addr_o), 32'(tw));
    endtask

    // Per-cycle compare against the model, plus hand-computed pins.
    always @(negedge clk) begin
        if (seen_rst) begin
            chk("busy", 32'(busy_o), e_busy);
            chk("done", 32'(done_o), e_done);
            chk("stage", 32'(stage_o), e_stage);
            chk("rd_en", 32'(rd_en_o), e_rd);
            chk("rd_a", 32'(rd_addr_a_o), e_a);
            chk("rd_b", 32'(rd_addr_b_o), e_b);
            chk("tw", 32'(tw_addr_o), e_tw);
            chk("wr_en", 32'(wr_en_o), e_wr);
            chk("wr_a", 32'(wr_addr_a_o), e_wa);
            chk("wr_b", 32'(wr_addr_b_o), e_wb);

            if (pin_zero) begin
                pin_zero = 1'b0;
                chk("pin_rst_zero",
                    32'({busy_o, done_o, stage_o, rd_en_o, rd_addr_a_o, rd_addr_b_o,
                         tw_addr_o, wr_en_o, wr_addr_a_o, wr_addr_b_o}), 0);
            end

            if (run_no == 1) begin
                case (mdl_t)
                    1:  pin_rd("pin_s0k0", 0, 1, 0);
                    2:  pin_rd("pin_s0k1", 2, 3, 0);
                    4:  begin
                            chk("pin_wr4_en", 32'(wr_en_o), 1);
                            chk("pin_wr4_a", 32'(wr_addr_a_o), 0);
                            chk("pin_wr4_b", 32'(wr_addr_b_o), 1);
                        end
                    8:  pin_rd("pin_s0k7", 14, 15, 0);
                    9:  chk("pin_drain_rd_en", 32'(rd_en_o), 0);
                    11: begin
                            chk("pin_wr11_a", 32'(wr_addr_a_o), 14);
                            chk("pin_wr11_b", 32'(wr_addr_b_o), 15);
                        end
                    12: pin_rd("pin_s1k0", 0, 2, 0);
                    13: pin_rd("pin_s1k1", 1, 3, 4);
                    14: pin_rd("pin_s1k2", 4, 6, 0);
                    39: begin
                            pin_rd("pin_s3k5", 5, 13, 5);
                            chk("pin_s3_stage", 32'(stage_o), 3);
                        end
                    44: begin
                            chk("pin_last_wr_en", 32'(wr_en_o), 1);
                            chk("pin_last_wr_a", 32'(wr_addr_a_o), 7);
                            chk("pin_last_wr_b", 32'(wr_addr_b_o), 15);
                            chk("pin_busy44", 32'(busy_o), 1);
                            chk("pin_done44", 32'(done_o), 0);
                        end
                    45: begin
                            chk("pin_done45", 32'(done_o), 1);
                            chk("pin_busy45", 32'(busy_o), 0);
                        end
                    default: ;
                endcase
            end
            if (run_no == 2 && mdl_t == 1) pin_rd("pin_run2_first", 0, 1, 0);
        end
    end

    task automatic drive(input logic st, input logic r);
        start_i = st;
        rst     = r;
        @(negedge clk);
    endtask

    initial begin
        start_i = 1'b0;
        rst     = 1'b1;
        repeat (3) drive(1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0);

        // Run 1: start at cycle 0, stray pulses at 10 (busy) and 45 (done), restart at 46.
        drive(1'b1, 1'b0);
        repeat (9) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (34) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        // Run 2: its cycle 0 here; reset in its cycle 20, restart in cycle 22.
        drive(1'b1, 1'b0);
        repeat (19) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (50) drive(1'b0, 1'b0);

        // Randomised starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 399) == 0));
        end
        repeat (60) drive(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

In-place radix-2 decimation-in-time FFT sequencer for the fixed-point FFT datapath.
- Walks all log2(N) stages and N/2 butterflies per stage.
- Issues dual read addresses and a twiddle-ROM address to the butterfly unit, and the matching write-back addresses after the butterfly pipeline latency.
- Provides a start/busy/done handshake to the host (test harness or top level).
- Sits between the data RAM, the twiddle ROM and the butterfly; contains no arithmetic on sample data.

## Interface
- N, 16: FFT size; power of two, ≥ 4.
- BFLY_LAT, 3: butterfly pipeline latency in cycles (read issue to write-back); ≥ 1.
- LOG2N, $clog2(N): derived; not overridden.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start request; ignored unless idle.
- busy_o  out  1  high from cycle after accepted start through the cycle before done_o.
- done_o  out  1  one-cycle pulse after the final write-back.
- stage_o  out  $clog2(LOG2N)  stage currently issuing.
- rd_en_o  out  1  read/butterfly issue strobe.
- rd_addr_a_o, rd_addr_b_o  out  LOG2N each  butterfly operand addresses.
- tw_addr_o  out  LOG2N-1  twiddle ROM index, valid with rd_en_o.
- wr_en_o  out  1  write-back strobe.
- wr_addr_a_o, wr_addr_b_o  out  LOG2N each  write-back addresses.

## Operation
- **States**
  - IDLE: start_i → RUN with stage s=0, butterfly index k=0.
  - RUN: issue one butterfly per cycle, k=0..N/2-1.
    - After k=N/2-1, go to DRAIN.
  - DRAIN: wait BFLY_LAT cycles so all writes of stage s land before stage s+1 reads them.
    - On exit, if s<LOG2N-1: s++, k=0, → RUN.
    - Otherwise → DONE.
  - DONE: assert done_o for one cycle → IDLE.
- **Address rule** (per issued butterfly, stage s):
  - span=1<<s; pos=k&(span-1); grp=k>>s.
  - a=(grp<<(s+1))|pos; b=a+span.
  - tw=pos<<(LOG2N-1-s).
- **Input order:** input data is bit-reversed in RAM before start; the output is natural order. The controller performs no reordering.
- **Write-back path:** wr_addr_a/b_o and wr_en_o are rd_addr_a/b_o and rd_en_o delayed by exactly BFLY_LAT cycles. Address arithmetic is unsigned; widths are fixed at LOG2N and never overflow.
- **start_i while busy:** ignored, with no effect on sequence or counters.
- **start_i in the DONE cycle:** ignored; a new start is accepted only in IDLE.
- **rst at any time:**
  - Next cycle is IDLE; all counters are zero.
  - The delay line is cleared, so no stale wr_en_o appears after reset.
- **Reset values:** every output is 0.

## Timing
- start_i is sampled high in cycle 0; the first rd_en_o is in cycle 1.
- Each stage occupies N/2+BFLY_LAT cycles (issue, then drain).
- Within a stage, issues are on consecutive cycles with no bubbles.
- The last write of the FFT is in cycle LOG2N·(N/2+BFLY_LAT).
- done_o is in the following cycle; busy_o falls in that same cycle.
- rd_en_o and wr_en_o may both be high in one cycle (steady RUN). Reads and writes then never target the same address, because they belong to the same stage and different butterflies.
- tw_addr_o changes in the same cycle as rd_addr_*_o; the ROM has one-cycle read latency, which is absorbed inside BFLY_LAT.

## Structure
- **fft_pkg:**
  - state enum (IDLE, RUN, DRAIN, DONE).
  - Pure function bfly_addr(s, k) returning a/b/tw.
  - Default N and BFLY_LAT constants.
- **fft_addr_delay:** a natural sub-module; a BFLY_LAT-deep shift register carrying {en, addr_a, addr_b} and cleared by rst.
- **fft_ctrl:** holds only the FSM, the s/k counters and the drain counter.

## Test plan
- N=16, BFLY_LAT=3, stage 0: start in cycle 0.
  - Cycles 1–8 give (a,b,tw) = (0,1,0), (2,3,0) … (14,15,0).
  - wr_* repeats that sequence in cycles 4–11.
- Stage 1: issues begin in cycle 12.
  - k=0 → (0,2,0); k=1 → (1,3,4); k=2 → (4,6,0).
- Stage 3: k=5 → (5,13,5).
  - Last write in cycle 44; done_o=1 in cycle 45 only; busy_o=0 from cycle 45.
- start_i pulsed in cycles 10 and 45: no change to sequence or done timing. A pulse in cycle 46 (IDLE) starts a new run with first read in cycle 47.
- rst in cycle 20 (mid stage 1): from cycle 21 all outputs are 0 and there is no wr_en_o afterward. A start in cycle 22 reproduces the full sequence from stage 0.
- N=8, BFLY_LAT=1: done_o in cycle 16; stage 2, k=3 → (3,7,3).
